fir_out_stage: RTL and testbench

//  Output conditioning stage directly downstream of the FIR filter.
//  - Consumes the filter result y_n whenever y_valid is high.
//  - Optionally block-averages (decimates) the results.
//  - Rounds and saturates each result to OUT_SIZE bits.
//  - Buffers the results in a small FIFO behind a valid/ready master handshake, so the pin-limited consumer can stall.

---
 rtl/fir_out_stage.sv | 198 +++++++++++++++++++
 tb/tb_fir_out_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_out_stage.sv
// fir_out_stage: block-averages FIR results, rounds/saturates them and queues them in a valid/ready FIFO.
// Define FIR_OUT_PEAK_EN to build the peak-magnitude tracker; otherwise peak is tied to zero.
module fir_out_stage #(
   parameter int Y_N_SIZE   = 14,
   parameter int OUT_SIZE   = 8,
   parameter int SHIFT      = 6,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic signed [Y_N_SIZE-1:0]         y_n,
   input  logic                               y_valid,
   input  logic        [1:0]                  decim_sel,
   input  logic                               clr,
   output logic signed [OUT_SIZE-1:0]         m_tdata,
   output logic                               m_tvalid,
   input  logic                               m_tready,
   output logic        [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                               ovf,
   output logic                               sat,
   output logic        [OUT_SIZE-1:0]         peak
);

   localparam int ACC_W = Y_N_SIZE + 3;
   // One extra bit so the rounding bias cannot wrap a full-scale 8-sample sum.
   localparam int RND_W = ACC_W + 1;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam logic signed [RND_W-1:0] OUT_MAX = RND_W'((2 ** (OUT_SIZE - 1)) - 1);
   localparam logic signed [RND_W-1:0] OUT_MIN = RND_W'(-(2 ** (OUT_SIZE - 1)));

   typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

   typedef struct packed {
      logic                       clamp;
      logic signed [OUT_SIZE-1:0] val;
   } rnd_t;

   function automatic rnd_t round_sat(input logic signed [ACC_W-1:0] a, input logic [1:0] sel);
      logic signed [RND_W-1:0] biased;
      logic signed [RND_W-1:0] shifted;
      rnd_t                    res;
      biased  = RND_W'(a) + (RND_W'(1) <<< (SHIFT + int'(sel) - 1));
      shifted = biased >>> (SHIFT + int'(sel));
      res.clamp = 1'b1;
      if (shifted > OUT_MAX)
         res.val = OUT_MAX[OUT_SIZE-1:0];
      else if (shifted < OUT_MIN)
         res.val = OUT_MIN[OUT_SIZE-1:0];
      else begin
         res.clamp = 1'b0;
         res.val   = shifted[OUT_SIZE-1:0];
      end
      return res;
   endfunction

   state_t                    state, state_nxt;
   logic [1:0]                n_sel, n_sel_nxt;
   logic [2:0]                count, count_nxt, blk_last;
   logic signed [ACC_W-1:0]   acc, acc_nxt, y_ext;
   logic                      open_blk;

   assign y_ext    = ACC_W'(y_n);
   assign blk_last = 3'((4'd1 << n_sel) - 4'd1);

   // Block accumulator: opens a block, sums N samples, then spends one cycle in EMIT
   always_comb begin
      state_nxt = state;
      n_sel_nxt = n_sel;
      count_nxt = count;
      acc_nxt   = acc;
      open_blk  = 1'b0;
      case (state)
         IDLE:  open_blk = y_valid;
         ACCUM: begin
            if (y_valid) begin
               acc_nxt = acc + y_ext;
               if (count == blk_last) begin
                  state_nxt = EMIT;
                  count_nxt = '0;
               end else begin
                  count_nxt = count + 3'd1;
               end
            end
         end
         EMIT: begin
            open_blk  = y_valid;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (open_blk) begin
         n_sel_nxt = decim_sel;
         acc_nxt   = y_ext;
         if (decim_sel == 2'd0) begin
            state_nxt = EMIT;
            count_nxt = '0;
         end else begin
            state_nxt = ACCUM;
            count_nxt = 3'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         n_sel <= '0;
         count <= '0;
         acc   <= '0;
      end else begin
         state <= state_nxt;
         n_sel <= n_sel_nxt;
         count <= count_nxt;
         acc   <= acc_nxt;
      end
   end

   // Round/saturate stage: evaluated during EMIT and pushed on the following edge
   rnd_t rnd;
   logic push, pop, full, do_push, drop;

   assign rnd     = round_sat(acc, n_sel);
   assign push    = (state == EMIT);
   assign full    = (fifo_level == (AW + 1)'(FIFO_DEPTH));
   assign pop     = m_tvalid & m_tready;
   assign do_push = push & (~full | pop);
   assign drop    = push & full & ~pop;

   logic signed [OUT_SIZE-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]              wr_ptr, rd_ptr;

   assign m_tdata  = mem[rd_ptr];
   assign m_tvalid = (fifo_level != '0);

   // Output FIFO
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= rnd.val;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf <= 1'b0;
         sat <= 1'b0;
      end else begin
         if (drop)
            ovf <= 1'b1;
         else if (clr)
            ovf <= 1'b0;
         if (push && rnd.clamp)
            sat <= 1'b1;
         else if (clr)
            sat <= 1'b0;
      end
   end

`ifdef FIR_OUT_PEAK_EN
   function automatic logic [OUT_SIZE-1:0] mag_sat(input logic signed [OUT_SIZE-1:0] v);
      if (v == OUT_MIN[OUT_SIZE-1:0])
         return OUT_MAX[OUT_SIZE-1:0];
      else if (v < 0)
         return -v;
      else
         return v;
   endfunction

   logic [OUT_SIZE-1:0] rnd_mag;
   assign rnd_mag = mag_sat(rnd.val);

   // A push coinciding with clr restarts the peak from that sample
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         peak <= '0;
      else if (clr)
         peak <= do_push ? rnd_mag : '0;
      else if (do_push && (rnd_mag > peak))
         peak <= rnd_mag;
   end
`else
   assign peak = '0;
`endif

endmodule

// File: tb/tb_fir_out_stage.sv
// Table-driven, scoreboarded bench for fir_out_stage (default parameters).
module tb_fir_out_stage;
   localparam int Y_N_SIZE   = 14;
   localparam int OUT_SIZE   = 8;
   localparam int SHIFT      = 6;
   localparam int FIFO_DEPTH = 4;

   logic                               clk = 1'b0;
   logic                               reset;
   logic signed [Y_N_SIZE-1:0]         y_n;
   logic                               y_valid;
   logic        [1:0]                  decim_sel;
   logic                               clr;
   logic signed [OUT_SIZE-1:0]         m_tdata;
   logic                               m_tvalid;
   logic                               m_tready;
   logic        [$clog2(FIFO_DEPTH):0] fifo_level;
   logic                               ovf;
   logic                               sat;
   logic        [OUT_SIZE-1:0]         peak;

   fir_out_stage #(
      .Y_N_SIZE(Y_N_SIZE), .OUT_SIZE(OUT_SIZE), .SHIFT(SHIFT), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .y_n(y_n), .y_valid(y_valid), .decim_sel(decim_sel),
      .clr(clr), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .fifo_level(fifo_level), .ovf(ovf), .sat(sat), .peak(peak)
   );

   always #5 clk = ~clk;

   typedef struct {
      int y;
      int exp;
      bit sat_ev;
   } vec_t;

   vec_t vecs[11];
   int   q[$];
   int   nchk = 0;
   int   nerr = 0;
   int   nout = 0;
   int   base;
   bit   exp_sat;

   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int y, input logic [1:0] sel);
      y_n       = Y_N_SIZE'(y);
      decim_sel = sel;
      y_valid   = 1'b1;
      tick();
      y_valid   = 1'b0;
   endtask

   task automatic drain();
      m_tready = 1'b1;
      for (int i = 0; i < 40 && (q.size() != 0 || m_tvalid); i++) tick();
      chk("drain_left", q.size(), 0);
      chk("drain_tvalid", int'(m_tvalid), 0);
   endtask

   // Scoreboard: every accepted beat is compared with the oldest expected value
   always @(negedge clk) begin
      if (!reset && m_tvalid && m_tready) begin
         nout++;
         if (q.size() == 0) begin
            chk("pop_unexpected", int'(m_tdata), 9999);
         end else begin
            int e;
            e = q.pop_front();
            chk($sformatf("pop%0d", nout), int'(m_tdata), e);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{100, 2, 0};
      vecs[1]  = '{-100, -2, 0};
      vecs[2]  = '{31, 0, 0};
      vecs[3]  = '{32, 1, 0};
      vecs[4]  = '{-32, 0, 0};
      vecs[5]  = '{-33, -1, 0};
      vecs[6]  = '{8130, 127, 0};
      vecs[7]  = '{-8192, -128, 0};
      vecs[8]  = '{8191, 127, 1};
      vecs[9]  = '{8160, 127, 1};
      vecs[10] = '{0, 0, 0};

      reset = 1'b1; y_n = '0; y_valid = 1'b0; decim_sel = 2'd0; clr = 1'b0; m_tready = 1'b1;
      repeat (2) tick();
      chk("rst_tvalid", int'(m_tvalid), 0);
      chk("rst_tdata", int'(m_tdata), 0);
      chk("rst_level", int'(fifo_level), 0);
      chk("rst_ovf", int'(ovf), 0);
      chk("rst_sat", int'(sat), 0);
      chk("rst_peak", int'(peak), 0);
      reset = 1'b0;
      tick();

      // Reset mid-block discards the partial sum
      send(1000, 2'd2);
      send(1000, 2'd2);
      reset = 1'b1;
      #1;
      chk("midrst_tvalid", int'(m_tvalid), 0);
      chk("midrst_level", int'(fifo_level), 0);
      tick();
      reset = 1'b0;
      tick();
      base = nout;
      q.push_back(1);
      repeat (4) send(64, 2'd2);
      repeat (6) tick();
      chk("midrst_outs", nout - base, 1);

      // N=1 vectors: one-edge latency, round half up, saturation
      exp_sat = 1'b0;
      for (int i = 0; i < 11; i++) begin
         q.push_back(vecs[i].exp);
         send(vecs[i].y, 2'd0);
         tick();
         exp_sat |= vecs[i].sat_ev;
         chk($sformatf("v%0d_tvalid", i), int'(m_tvalid), 1);
         chk($sformatf("v%0d_tdata", i), int'(m_tdata), vecs[i].exp);
         chk($sformatf("v%0d_sat", i), int'(sat), int'(exp_sat));
      end
      drain();

      // clr in the same cycle as a saturating push: the set wins
      clr = 1'b1; tick(); clr = 1'b0;
      chk("clr_sat", int'(sat), 0);
      q.push_back(127);
      send(8191, 2'd0);
      clr = 1'b1; tick(); clr = 1'b0;
      chk("clr_vs_set_sat", int'(sat), 1);
      clr = 1'b1; tick(); clr = 1'b0;
      chk("clr_sat2", int'(sat), 0);
      drain();

      // Decimation: N=4, 2, 8 and mid-block decim_sel change
      q.push_back(1);
      repeat (4) send(64, 2'd2);
      tick();
      chk("n4_tvalid", int'(m_tvalid), 1);
      chk("n4_tdata", int'(m_tdata), 1);
      q.push_back(0);
      repeat (4) send(-1, 2'd2);
      q.push_back(1);
      repeat (2) send(64, 2'd1);
      q.push_back(127);
      repeat (8) send(8191, 2'd3);
      tick();
      chk("n8_sat", int'(sat), 1);
      q.push_back(-128);
      repeat (8) send(-8192, 2'd3);
      drain();
      base = nout;
      q.push_back(2);
      send(100, 2'd2);
      send(100, 2'd2);
      send(100, 2'd0);
      send(100, 2'd0);
      q.push_back(3);
      send(200, 2'd0);
      drain();
      chk("midsel_outs", nout - base, 2);
      clr = 1'b1; tick(); clr = 1'b0;

      // Stalled consumer: fifth push is dropped and flags ovf
      m_tready = 1'b0;
      base = nout;
      for (int i = 1; i <= 4; i++) q.push_back(i);
      y_valid = 1'b1;
      decim_sel = 2'd0;
      for (int i = 1; i <= 5; i++) begin
         y_n = Y_N_SIZE'(64 * i);
         tick();
      end
      y_valid = 1'b0;
      repeat (2) tick();
      chk("full_level", int'(fifo_level), 4);
      chk("full_ovf", int'(ovf), 1);
      chk("full_head", int'(m_tdata), 1);
      tick();
      chk("stall_stable", int'(m_tdata), 1);
      drain();
      chk("ovf_outs", nout - base, 4);
      chk("ovf_sticky", int'(ovf), 1);
      chk("drain_level", int'(fifo_level), 0);
      clr = 1'b1; tick(); clr = 1'b0;
      chk("clr_ovf", int'(ovf), 0);

      // Full FIFO with simultaneous push and pop
      m_tready = 1'b0;
      base = nout;
      for (int i = 6; i <= 10; i++) q.push_back(i);
      y_valid = 1'b1;
      for (int i = 6; i <= 10; i++) begin
         y_n = Y_N_SIZE'(64 * i);
         tick();
      end
      y_valid = 1'b0;
      chk("pp_pre_level", int'(fifo_level), 4);
      m_tready = 1'b1;
      tick();
      m_tready = 1'b0;
      chk("pp_level", int'(fifo_level), 4);
      chk("pp_ovf", int'(ovf), 0);
      chk("pp_head", int'(m_tdata), 7);
      drain();
      chk("pp_outs", nout - base, 5);

`ifdef FIR_OUT_PEAK_EN
      clr = 1'b1; tick(); clr = 1'b0;
      chk("peak_clr0", int'(peak), 0);
      q.push_back(3);
      send(192, 2'd0);
      q.push_back(-90);
      send(-5760, 2'd0);
      q.push_back(40);
      send(2560, 2'd0);
      tick();
      chk("peak_90", int'(peak), 90);
      drain();
      clr = 1'b1; tick(); clr = 1'b0;
      chk("peak_clr", int'(peak), 0);
      chk("peak_clr_ovf", int'(ovf), 0);
      chk("peak_clr_sat", int'(sat), 0);
`else
      chk("peak_off", int'(peak), 0);
      q.push_back(-128);
      send(-8192, 2'd0);
      tick();
      chk("peak_off2", int'(peak), 0);
      drain();
`endif

      chk("final_queue", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
      $finish;
   end
endmodule
